// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Resolves data-memory waits, MEM-stage redirects and load-use hazards, in that priority.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_LEN = 5,
  parameter int MEM_TIMEOUT  = 16,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_ADDR_LEN-1:0] if_id_rs,
  input  logic [REG_ADDR_LEN-1:0] if_id_rt,
  input  logic                    if_id_uses_rt,
  input  logic [REG_ADDR_LEN-1:0] id_ex_rt,
  input  logic                    id_ex_mem_read,
  input  logic                    branch_flag_mem,
  input  logic                    zero_mem,
  input  logic                    jump_flag_mem,
  input  logic                    mem_read_flag_mem,
  input  logic                    mem_write_flag_mem,
  input  logic                    dmem_ready,
  output logic                    pc_en,
  output logic                    pc_redirect,
  output logic                    if_id_en,
  output logic                    if_id_flush,
  output logic                    id_ex_en,
  output logic                    id_ex_flush,
  output logic                    ex_mem_en,
  output logic                    ex_mem_flush,
  output logic                    mem_wb_bubble,
  output logic                    mem_timeout,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        flush_events
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t          state;
  logic [WC_W-1:0] wait_cnt;
  logic            dmem_req;
  logic            force_rel;
  logic            freeze;
  logic            redirect;
  logic            load_use;

  assign dmem_req  = mem_read_flag_mem | mem_write_flag_mem;
  assign force_rel = (state == MEM_WAIT) && (wait_cnt == WC_W'(MEM_TIMEOUT - 1));
  assign freeze    = dmem_req & ~dmem_ready & ~force_rel;
  assign redirect  = (branch_flag_mem & zero_mem) | jump_flag_mem;
  assign load_use  = id_ex_mem_read && (id_ex_rt != '0) &&
                     ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // Outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    pc_en         = 1'b0;
    pc_redirect   = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst_n) begin
      if (freeze) begin
        mem_wb_bubble = 1'b1;
      end else if (redirect) begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_en     = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_en    = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (freeze) begin
      state    <= MEM_WAIT;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 1'b1 : WC_W'(1);
      if (~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
    end else begin
      // Released by the watchdog rather than by memory: remember it until reset.
      if (force_rel && !dmem_ready) mem_timeout <= 1'b1;
      state    <= RUN;
      wait_cnt <= '0;
      if (redirect) begin
        if (~&flush_events) flush_events <= flush_events + 1'b1;
      end else if (load_use) begin
        if (~&stall_cycles) stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int RA  = 5;
  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  localparam logic [8:0] K_ZERO   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] K_NORMAL = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] K_LU     = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] K_REDIR  = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] K_FREEZE = 9'b0_0_0_0_0_0_0_0_1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [RA-1:0] if_id_rs = '0, if_id_rt = '0, id_ex_rt = '0;
  logic if_id_uses_rt = 0, id_ex_mem_read = 0, branch_flag_mem = 0, zero_mem = 0;
  logic jump_flag_mem = 0, mem_read_flag_mem = 0, mem_write_flag_mem = 0, dmem_ready = 0;
  logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, ex_mem_flush, mem_wb_bubble, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [8:0] outs;

  int n_checks = 0;
  int n_fail = 0;

  // Model: are we inside a memory wait, how many frozen cycles so far, flags and counters.
  bit m_wait;
  int m_frozen;
  bit m_to;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  assign outs = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                 ex_mem_en, ex_mem_flush, mem_wb_bubble};

  pipeline_hazard_ctrl #(.REG_ADDR_LEN(RA), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_rt(id_ex_rt), .id_ex_mem_read(id_ex_mem_read),
    .branch_flag_mem(branch_flag_mem), .zero_mem(zero_mem), .jump_flag_mem(jump_flag_mem),
    .mem_read_flag_mem(mem_read_flag_mem), .mem_write_flag_mem(mem_write_flag_mem),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  function automatic bit m_is_frozen();
    bit req = mem_read_flag_mem | mem_write_flag_mem;
    bit watchdog = m_wait && (m_frozen >= TO - 1);
    return req && !dmem_ready && !watchdog;
  endfunction

  function automatic bit m_is_redirect();
    return (branch_flag_mem && zero_mem) || jump_flag_mem;
  endfunction

  function automatic bit m_is_lu();
    if (!id_ex_mem_read || id_ex_rt == 0) return 0;
    return (id_ex_rt == if_id_rs) || (if_id_uses_rt && id_ex_rt == if_id_rt);
  endfunction

  function automatic logic [8:0] m_outs();
    if (!rst_n) return K_ZERO;
    if (m_is_frozen()) return K_FREEZE;
    if (m_is_redirect()) return K_REDIR;
    if (m_is_lu()) return K_LU;
    return K_NORMAL;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_frozen = 0; m_to = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step();
    if (m_is_frozen()) begin
      m_frozen = m_wait ? m_frozen + 1 : 1;
      m_wait = 1;
      if (m_stall < MAX) m_stall++;
    end else begin
      if (m_wait && m_frozen >= TO - 1 && !dmem_ready) m_to = 1;
      m_wait = 0;
      m_frozen = 0;
      if (m_is_redirect()) begin
        if (m_flush < MAX) m_flush++;
      end else if (m_is_lu()) begin
        if (m_stall < MAX) m_stall++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input int rs, input int rt, input bit uses, input int ert, input bit erd,
                        input bit br, input bit z, input bit j, input bit mrd, input bit mwr,
                        input bit rdy);
    if_id_rs = RA'(rs); if_id_rt = RA'(rt); if_id_uses_rt = uses;
    id_ex_rt = RA'(ert); id_ex_mem_read = erd;
    branch_flag_mem = br; zero_mem = z; jump_flag_mem = j;
    mem_read_flag_mem = mrd; mem_write_flag_mem = mwr; dmem_ready = rdy;
  endtask

  task automatic set_idle();
    set_in(1, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(2, 2, 1, 2, 1, 1, 1, 1, 1, 1, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_ZERO) begin n_fail++; $display("FAIL reset_outs: got %b expected %b", outs, K_ZERO); end
    n_checks++;
    if (stall_cycles !== 0 || flush_events !== 0 || mem_timeout !== 0) begin
      n_fail++;
      $display("FAIL reset_regs: got stall=%0d flush=%0d to=%b expected 0 0 0", stall_cycles, flush_events, mem_timeout);
    end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(2, 5, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_LU) begin n_fail++; $display("FAIL lu_stall: got %b expected %b", outs, K_LU); end
    cyc();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (outs !== K_NORMAL) begin n_fail++; $display("FAIL lu_next_normal: got %b expected %b", outs, K_NORMAL); end
    n_checks++;
    if (stall_cycles !== 1) begin n_fail++; $display("FAIL lu_count: got %0d expected 1", stall_cycles); end
    cyc();
  endtask

  task automatic test_no_stall();
    do_reset();
    set_in(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_NORMAL) begin n_fail++; $display("FAIL lu_reg0: got %b expected %b", outs, K_NORMAL); end
    cyc();
    set_in(4, 3, 0, 3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_NORMAL) begin n_fail++; $display("FAIL lu_rt_unused: got %b expected %b", outs, K_NORMAL); end
    cyc();
    set_in(4, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_LU) begin n_fail++; $display("FAIL lu_rt_used: got %b expected %b", outs, K_LU); end
    cyc();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 1) begin n_fail++; $display("FAIL no_stall_count: got %0d expected 1", stall_cycles); end
  endtask

  task automatic test_redirect();
    do_reset();
    set_in(2, 5, 1, 2, 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_REDIR) begin n_fail++; $display("FAIL beq_over_lu: got %b expected %b", outs, K_REDIR); end
    cyc();
    set_in(2, 5, 1, 2, 1, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_LU) begin n_fail++; $display("FAIL beq_not_taken: got %b expected %b", outs, K_LU); end
    n_checks++;
    if (flush_events !== 1 || stall_cycles !== 0) begin
      n_fail++;
      $display("FAIL beq_counts: got flush=%0d stall=%0d expected 1 0", flush_events, stall_cycles);
    end
    cyc();
    set_in(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if (outs !== K_REDIR) begin n_fail++; $display("FAIL jump: got %b expected %b", outs, K_REDIR); end
    cyc();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (flush_events !== 2) begin n_fail++; $display("FAIL jump_count: got %0d expected 2", flush_events); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    set_in(1, 2, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs !== K_FREEZE) begin n_fail++; $display("FAIL mem_freeze%0d: got %b expected %b", i, outs, K_FREEZE); end
      cyc();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== K_NORMAL) begin n_fail++; $display("FAIL mem_release: got %b expected %b", outs, K_NORMAL); end
    cyc();
    set_in(1, 2, 0, 3, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk);
    n_checks++;
    if (outs !== K_NORMAL) begin n_fail++; $display("FAIL mem_ready_first: got %b expected %b", outs, K_NORMAL); end
    cyc();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== 3 || mem_timeout !== 0) begin
      n_fail++;
      $display("FAIL mem_counts: got stall=%0d to=%b expected 3 0", stall_cycles, mem_timeout);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_in(1, 2, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs !== K_FREEZE) begin n_fail++; $display("FAIL to_freeze%0d: got %b expected %b", i, outs, K_FREEZE); end
      cyc();
    end
    @(negedge clk);
    n_checks++;
    if (outs !== K_NORMAL) begin n_fail++; $display("FAIL to_forced: got %b expected %b", outs, K_NORMAL); end
    n_checks++;
    if (mem_timeout !== 0) begin n_fail++; $display("FAIL to_early: got %b expected 0", mem_timeout); end
    cyc();
    set_idle();
    repeat (3) cyc();
    @(negedge clk);
    n_checks++;
    if (mem_timeout !== 1 || stall_cycles !== TO - 1) begin
      n_fail++;
      $display("FAIL to_sticky: got to=%b stall=%0d expected 1 %0d", mem_timeout, stall_cycles, TO - 1);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_in(1, 2, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (outs !== K_ZERO || stall_cycles !== 0 || mem_timeout !== 0) begin
      n_fail++;
      $display("FAIL async_reset: got outs=%b stall=%0d to=%b expected 0 0 0", outs, stall_cycles, mem_timeout);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < TO + 1; i++) begin
      #1;
      n_checks++;
      if (outs !== m_outs() || stall_cycles !== CW'(m_stall)) begin
        n_fail++;
        $display("FAIL after_reset%0d: got %b/%0d expected %b/%0d", i, outs, stall_cycles, m_outs(), m_stall);
      end
      cyc();
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_in(6, 1, 0, 6, 1, 0, 0, 0, 0, 0, 0);
    repeat (MAX + 5) cyc();
    set_in(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    repeat (MAX + 5) cyc();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (stall_cycles !== CW'(MAX) || flush_events !== CW'(MAX)) begin
      n_fail++;
      $display("FAIL saturate: got stall=%0d flush=%0d expected %0d %0d", stall_cycles, flush_events, MAX, MAX);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 1), ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0));
      @(negedge clk);
      n_checks++;
      if (outs !== m_outs() || stall_cycles !== CW'(m_stall) || flush_events !== CW'(m_flush) ||
          mem_timeout !== m_to) begin
        n_fail++;
        $display("FAIL random%0d: got %b s=%0d f=%0d t=%b expected %b s=%0d f=%0d t=%b", i, outs,
                 stall_cycles, flush_events, mem_timeout, m_outs(), m_stall, m_flush, m_to);
      end
      cyc();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
